// File: rtl/demux_tdm.sv
// Purpose: splits a 2-channel, 4-bit-per-channel TDM serial stream back into
//          words y0/y1. Latency is sync at cycle T to valid at T+8 with no
//          pauses; notoe pauses add cycles one for one.
// Backpressure: valid/ready. A frame that completes while the previous one is
//          still unconsumed is dropped, and the sticky overrun flag is set.
// Ports: clk, reset (sync, active-high), notoe (active-low sample enable),
//        d/sync (serial data, frame strobe), y0/y1/valid/ready (output word
//        handshake), overrun (sticky drop flag), c (output-toggle counter).
module demux_tdm #(
    parameter int FRAME_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        notoe,
    input  logic        d,
    input  logic        sync,
    output logic [3:0]  y0,
    output logic [3:0]  y1,
    output logic        valid,
    input  logic        ready,
    output logic        overrun,
    output logic [15:0] c
);

    localparam logic [2:0] LAST_SLOT = 3'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  k, k_nxt;
    logic [3:0]  sh0, sh0_nxt;
    logic [3:0]  sh1, sh1_nxt;
    logic [2:0]  slot;
    logic        cap;
    logic        complete;
    logic        load;
    logic [15:0] c_nxt;

    // Sequencing and slot capture. notoe gates only the sampling of d/sync;
    // the output handshake below runs every cycle.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        sh0_nxt   = sh0;
        sh1_nxt   = sh1;
        slot      = k;
        cap       = 1'b0;
        complete  = 1'b0;
        if (!notoe) begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        cap       = 1'b1;
                        slot      = 3'd0;
                        k_nxt     = 3'd1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sync) begin
                        // Resync: the partial frame is abandoned; stale bits
                        // are overwritten before this new frame completes.
                        cap   = 1'b1;
                        slot  = 3'd0;
                        k_nxt = 3'd1;
                    end else begin
                        cap   = 1'b1;
                        slot  = k;
                        k_nxt = k + 3'd1;
                        if (k == LAST_SLOT) begin
                            complete  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // Even slots feed channel 0, odd slots channel 1, LSB first.
        if (cap) begin
            if (slot[0]) sh1_nxt[slot[2:1]] = d;
            else         sh0_nxt[slot[2:1]] = d;
        end
    end

    // A completed frame is accepted only if the output register is free or
    // being consumed in the same cycle.
    assign load = complete && (!valid || ready);

    // c is rewritten every cycle (holding by default) so that its next value
    // is always a function of its current value.
    always_comb begin
        c_nxt = c;
        if (load && ({sh1_nxt, sh0_nxt} != {y1, y0}) && (c != 16'hFFFF))
            c_nxt = c + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= 3'd0;
            sh0     <= 4'd0;
            sh1     <= 4'd0;
            y0      <= 4'd0;
            y1      <= 4'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            c       <= 16'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            sh0   <= sh0_nxt;
            sh1   <= sh1_nxt;
            c     <= c_nxt;
            if (load) begin
                y0    <= sh0_nxt;
                y1    <= sh1_nxt;
                valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_tdm.sv
// Directed, table-driven bench for demux_tdm: each row is one clock of
// stimulus plus the outputs expected just after that edge.
module tb_demux_tdm;

    logic        clk;
    logic        reset;
    logic        notoe;
    logic        d;
    logic        sync;
    logic        ready;
    logic [3:0]  y0;
    logic [3:0]  y1;
    logic        valid;
    logic        overrun;
    logic [15:0] c;

    int checks = 0;
    int errors = 0;

    demux_tdm #(.FRAME_BITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .notoe   (notoe),
        .d       (d),
        .sync    (sync),
        .y0      (y0),
        .y1      (y1),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .c       (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        noe;
        logic        dd;
        logic        sy;
        logic        rdy;
        logic [3:0]  ey0;
        logic [3:0]  ey1;
        logic        ev;
        logic        eo;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic noe, input logic dd,
                                input logic sy, input logic rdy,
                                input logic [3:0] ey0, input logic [3:0] ey1,
                                input logic ev, input logic eo, input logic [15:0] ec);
        vec_t v;
        v.rst = rst; v.noe = noe; v.dd = dd; v.sy = sy; v.rdy = rdy;
        v.ey0 = ey0; v.ey1 = ey1; v.ev = ev; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic noe, input logic dd,
                        input logic sy, input logic rdy);
        reset = rst; notoe = noe; d = dd; sync = sy; ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] ey0,
                           input logic [3:0] ey1, input logic ev, input logic eo,
                           input logic [15:0] ec);
        chk({tag, ".y0"}, idx, 16'(y0), 16'(ey0));
        chk({tag, ".y1"}, idx, 16'(y1), 16'(ey1));
        chk({tag, ".valid"}, idx, 16'(valid), 16'(ev));
        chk({tag, ".overrun"}, idx, 16'(overrun), 16'(eo));
        chk({tag, ".c"}, idx, c, ec);
    endtask

    initial begin
        reset = 1'b1; notoe = 1'b0; d = 1'b0; sync = 1'b0; ready = 1'b0;

        //   rst noe d  sy rdy   y0    y1   v  o  c
        add(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);   // reset state
        // Nominal frame A/5, ready=1
        add(0, 0, 0, 1, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 1, 0, 16'd1);   // T+8
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);   // T+9 consumed
        // Same frame, 3-cycle pause after slot 3 with garbage on d/sync
        add(0, 0, 0, 1, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 1, 1, 1, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 1, 1, 1, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 1, 1, 1, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 1, 0, 16'd1);   // T+11, identical -> c held
        add(0, 1, 0, 0, 1, 4'hA, 4'h5, 0, 0, 16'd1);   // ready honoured while paused
        // Resync at slot 5, then all-ones frame
        add(0, 0, 0, 1, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 0, 0, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 1, 0, 4'hA, 4'h5, 0, 0, 16'd1);   // resync
        for (int i = 0; i < 6; i++)
            add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 0, 16'd1);
        add(0, 0, 1, 0, 0, 4'hF, 4'hF, 1, 0, 16'd2);
        add(0, 0, 0, 0, 1, 4'hF, 4'hF, 0, 0, 16'd2);
        // Overrun: 3/C then 9/6 back to back, ready=0
        add(0, 0, 1, 1, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 16'd2);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 1, 1, 0, 4'h3, 4'hC, 1, 0, 16'd3);   // no-gap second frame
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 16'd3);
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);   // dropped
        // Completion while valid=1 and ready=1 -> stays valid, y updates
        add(0, 0, 0, 1, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 0, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 1, 16'd3);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 1, 1, 16'd4);
        add(0, 0, 0, 0, 1, 4'hA, 4'h5, 0, 1, 16'd4);
        // Reset at slot 4 (with sync/ready also high), then a clean frame
        add(0, 0, 1, 1, 0, 4'hA, 4'h5, 0, 1, 16'd4);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 1, 16'd4);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 1, 16'd4);
        add(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 1, 16'd4);
        add(1, 0, 1, 1, 1, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 1, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);
        add(0, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 16'd1);
        // Reset drops pending valid data
        add(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 16'd0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].noe, tbl[i].dd, tbl[i].sy, tbl[i].rdy);
            chk_all("vec", i, tbl[i].ey0, tbl[i].ey1, tbl[i].ev, tbl[i].eo, tbl[i].ec);
        end

        // Counter saturation: preload c to FFFF, then apply changing loads.
        force dut.c = 16'hFFFF;
        step(0, 0, 0, 0, 0);
        release dut.c;
        step(0, 0, 0, 0, 0);
        chk("sat.preload", 0, c, 16'hFFFF);
        begin
            logic [7:0] fa;
            fa = 8'b0110_0110;   // slot i -> fa[i]: 0,1,1,0,0,1,1,0 (A/5)
            for (int i = 0; i < 8; i++) step(0, 0, fa[i], (i == 0), 1'b1);
        end
        chk_all("sat.fa", 1, 4'hA, 4'h5, 1'b1, 1'b0, 16'hFFFF);
        for (int i = 0; i < 8; i++) step(0, 0, 1'b1, (i == 0), 1'b1);
        chk_all("sat.ff", 2, 4'hF, 4'hF, 1'b1, 1'b0, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
